// File: rtl/core_boot_pkg.sv
// rtl/core_boot_pkg.sv - shared state type and constants for the core boot sequencer
package core_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RST_HOLD,
    ST_RUN,
    ST_DONE
  } boot_state_t;

  localparam int unsigned TOHOST_PASS_VAL     = 1;
  localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;
  localparam int unsigned EXIT_CODE_SHIFT     = 1;

endpackage

// File: rtl/up_counter.sv
// rtl/up_counter.sv - free-running up counter with synchronous clear, shared for reset hold and watchdog
module up_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count_val
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_val <= '0;
    end else if (clear) begin
      count_val <= '0;
    end else if (en) begin
      count_val <= count_val + WIDTH'(1);
    end
  end

endmodule

// File: rtl/core_boot_ctrl.sv
// rtl/core_boot_ctrl.sv - loads an image into IMEM, releases the core, and watches tohost for end of test
module core_boot_ctrl
  import core_boot_pkg::*;
#(
  parameter int                ADDR_W            = 32,
  parameter int                DATA_W            = 32,
  parameter int                RESET_HOLD_CYCLES = 6,
  parameter int                WATCHDOG_CYCLES   = 1000,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR       = ADDR_W'(DEFAULT_TOHOST_ADDR)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_clk_en,
  output logic              core_rstn,
  input  logic              dmem_we,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-2:0] exit_code
);

  localparam int WD_W   = $clog2(WATCHDOG_CYCLES);
  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int CNT_W  = (WD_W > HOLD_W) ? WD_W : HOLD_W;

  boot_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             handshake;
  logic             hold_end;
  logic             wd_expired;
  logic             tohost_hit;
  logic             cnt_clr;
  logic             cnt_en;

  assign load_ready = (state == ST_LOAD);
  assign handshake  = load_valid && load_ready;
  assign hold_end   = (state == ST_RST_HOLD) && (cnt == CNT_W'(RESET_HOLD_CYCLES - 1));
  assign wd_expired = (cnt == CNT_W'(WATCHDOG_CYCLES - 1));
  assign tohost_hit = dmem_we && (dmem_addr == TOHOST_ADDR);

  // Held clear through LOAD so RST_HOLD starts at 0; cleared again on the RST_HOLD->RUN edge.
  assign cnt_clr = (state == ST_LOAD) || hold_end;
  assign cnt_en  = (state == ST_RST_HOLD) || (state == ST_RUN);

  up_counter #(.WIDTH(CNT_W)) u_watchdog (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (cnt_clr),
    .en        (cnt_en),
    .count_val (cnt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      core_clk_en <= 1'b0;
      core_rstn   <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      exit_code   <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (handshake) begin
            imem_we    <= 1'b1;
            imem_addr  <= {load_addr[ADDR_W-1:2], 2'b00};
            imem_wdata <= load_data;
            if (load_last) begin
              state       <= ST_RST_HOLD;
              core_clk_en <= 1'b1;
            end
          end
        end
        ST_RST_HOLD: begin
          if (hold_end) begin
            state     <= ST_RUN;
            core_rstn <= 1'b1;
          end
        end
        ST_RUN: begin
          // A tohost store on the expiry cycle still counts as a normal end of test.
          if (tohost_hit) begin
            state       <= ST_DONE;
            core_clk_en <= 1'b0;
            done        <= 1'b1;
            if (dmem_wdata == DATA_W'(TOHOST_PASS_VAL)) begin
              pass      <= 1'b1;
              exit_code <= '0;
            end else begin
              pass      <= 1'b0;
              exit_code <= (DATA_W-1)'(dmem_wdata >> EXIT_CODE_SHIFT);
            end
          end else if (wd_expired) begin
            state       <= ST_DONE;
            core_clk_en <= 1'b0;
            done        <= 1'b1;
            timeout     <= 1'b1;
            pass        <= 1'b0;
            exit_code   <= '0;
          end
        end
        ST_DONE: begin
          if (start) begin
            state     <= ST_LOAD;
            core_rstn <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            exit_code <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_boot_ctrl.sv
// tb/tb_core_boot_ctrl.sv - directed and randomized checks of core_boot_ctrl against a behavioural model
module tb_core_boot_ctrl;

  localparam int          HOLD   = 6;
  localparam int          WD     = 1000;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic        clk        = 1'b0;
  logic        rstn       = 1'b0;
  logic        start      = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_last  = 1'b0;
  logic [31:0] load_addr  = '0;
  logic [31:0] load_data  = '0;
  logic        dmem_we    = 1'b0;
  logic [31:0] dmem_addr  = '0;
  logic [31:0] dmem_wdata = '0;

  logic        load_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_clk_en;
  logic        core_rstn;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [30:0] exit_code;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  core_boot_ctrl #(
    .ADDR_W            (32),
    .DATA_W            (32),
    .RESET_HOLD_CYCLES (HOLD),
    .WATCHDOG_CYCLES   (WD),
    .TOHOST_ADDR       (TOHOST)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_last   (load_last),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .core_clk_en (core_clk_en),
    .core_rstn   (core_rstn),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .exit_code   (exit_code)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chkb({tag, "_load_ready"}, load_ready, 1'b0);
    chkb({tag, "_imem_we"}, imem_we, 1'b0);
    chkb({tag, "_core_clk_en"}, core_clk_en, 1'b0);
    chkb({tag, "_core_rstn"}, core_rstn, 1'b0);
    chkb({tag, "_done"}, done, 1'b0);
    chkb({tag, "_pass"}, pass, 1'b0);
    chkb({tag, "_timeout"}, timeout, 1'b0);
    chk({tag, "_imem_addr"}, imem_addr, 32'h0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'h0);
    chk({tag, "_exit_code"}, {1'b0, exit_code}, 32'h0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chkb("start_load_ready", load_ready, 1'b1);
    chkb("start_done_clr", done, 1'b0);
    chkb("start_pass_clr", pass, 1'b0);
    chkb("start_timeout_clr", timeout, 1'b0);
    chk("start_exit_clr", {1'b0, exit_code}, 32'h0);
    chkb("start_core_rstn", core_rstn, 1'b0);
    chkb("start_core_clk_en", core_clk_en, 1'b0);
  endtask

  // Streams n words; returns at the first RUN cycle after checking the reset-hold length.
  task automatic load_image(input int n, input bit directed);
    logic [31:0] a;
    logic [31:0] d;
    int          gap;
    int          k;
    for (int i = 0; i < n; i++) begin
      gap = directed ? 0 : int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        load_valid = 1'b0;
        load_addr  = $urandom;
        step();
        chkb("imem_we_idle", imem_we, 1'b0);
      end
      a = directed ? 32'(i * 4) : ($urandom & 32'h0000_0fff);
      d = directed ? ((i == n - 1) ? 32'h0010_0073 : 32'h0000_0013) : $urandom;
      load_valid = 1'b1;
      load_addr  = a;
      load_data  = d;
      load_last  = (i == n - 1);
      chkb("load_ready", load_ready, 1'b1);
      step();
      load_valid = 1'b0;
      load_last  = 1'b0;
      chkb("imem_we", imem_we, 1'b1);
      chk("imem_addr", imem_addr, a & ~32'h3);
      chk("imem_wdata", imem_wdata, d);
      if (i < n - 1) begin
        chkb("clk_en_during_load", core_clk_en, 1'b0);
      end else begin
        chkb("clk_en_hold_start", core_clk_en, 1'b1);
        chkb("core_rstn_hold_start", core_rstn, 1'b0);
        chkb("load_ready_after_last", load_ready, 1'b0);
      end
    end
    k = 0;
    while (!core_rstn && k < 50) begin
      step();
      k++;
    end
    chk("rst_hold_len", 32'(k), 32'(HOLD));
    chkb("clk_en_run", core_clk_en, 1'b1);
  endtask

  // tohost_at < 0 means no tohost store; the model derives when and how the run ends.
  task automatic run_phase(input int tohost_at, input logic [31:0] val);
    bit          hit;
    int          done_at;
    logic [31:0] code;
    hit     = (tohost_at >= 0) && (tohost_at < WD);
    done_at = hit ? tohost_at + 1 : WD;
    code    = (hit && val != 32'd1) ? (val >> 1) : 32'h0;
    for (int r = 0; r < done_at; r++) begin
      chk("running", {29'h0, done, core_clk_en, core_rstn}, 32'h3);
      if (r == tohost_at) begin
        dmem_we = 1'b1; dmem_addr = TOHOST; dmem_wdata = val; start = 1'b0;
      end else if (r == 2) begin
        dmem_we = 1'b1; dmem_addr = TOHOST + 32'h4; dmem_wdata = 32'd1; start = 1'b0;
      end else begin
        dmem_we    = ($urandom_range(0, 3) == 0);
        dmem_addr  = $urandom;
        if (dmem_addr == TOHOST) dmem_addr = TOHOST ^ 32'h4;
        dmem_wdata = $urandom_range(0, 1);
        start      = (r == 3) || ($urandom_range(0, 63) == 0);
      end
      step();
    end
    dmem_we = 1'b0;
    start   = 1'b0;
    chkb("done", done, 1'b1);
    chkb("pass", pass, hit && (val == 32'd1));
    chkb("timeout", timeout, !hit);
    chk("exit_code", {1'b0, exit_code}, code);
    chkb("done_clk_en", core_clk_en, 1'b0);
    chkb("done_core_rstn", core_rstn, 1'b1);
    dmem_we = 1'b1; dmem_addr = TOHOST; dmem_wdata = $urandom;
    step();
    dmem_we = 1'b0;
    chkb("done_sticky", done, 1'b1);
    chkb("pass_sticky", pass, hit && (val == 32'd1));
  endtask

  initial begin
    int          t;
    logic [31:0] v;

    repeat (3) step();
    check_reset("por");
    rstn = 1'b1;
    load_valid = 1'b1; load_last = 1'b1; load_addr = 32'h10;
    dmem_we = 1'b1; dmem_addr = TOHOST; dmem_wdata = 32'd1;
    step();
    step();
    load_valid = 1'b0; load_last = 1'b0; dmem_we = 1'b0;
    check_reset("idle");

    pulse_start(); load_image(4, 1'b1); run_phase(5, 32'd1);
    pulse_start(); load_image(4, 1'b1); run_phase(7, 32'h0000_000b);
    pulse_start(); load_image(3, 1'b0); run_phase(-1, 32'd0);
    pulse_start(); load_image(2, 1'b0); run_phase(WD - 1, 32'd1);

    for (int i = 0; i < 5; i++) begin
      t = int'($urandom_range(0, 40));
      v = ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom;
      pulse_start();
      load_image(int'($urandom_range(1, 6)), 1'b0);
      run_phase(t, v);
    end

    pulse_start();
    load_valid = 1'b1; load_addr = 32'h24; load_data = 32'hdead_beef;
    step();
    load_valid = 1'b0;
    chkb("mid_load_we", imem_we, 1'b1);
    rstn = 1'b0;
    #1;
    check_reset("rst_mid_load");
    step();
    rstn = 1'b1;
    step();
    check_reset("after_load_rst");

    pulse_start();
    load_image(2, 1'b0);
    repeat (5) step();
    chkb("mid_run_rstn", core_rstn, 1'b1);
    rstn = 1'b0;
    #1;
    check_reset("rst_mid_run");
    step();
    rstn = 1'b1;
    step();

    pulse_start(); load_image(4, 1'b1); run_phase(10, 32'd1);
    pulse_start(); load_image(4, 1'b1); run_phase(12, 32'h0000_0040);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/core_boot_ctrl.md
# core_boot_ctrl

Bench- and FPGA-side sequencer that sits directly upstream of the core top. It streams a program image into instruction memory, then drives the core's clock-gate enable and reset release. It monitors core stores for the tohost end-of-test write and stops the core on pass/fail or on watchdog expiry. It replaces ad-hoc delays and reset tasks with one deterministic cycle-accurate controller.

## Interface
- ADDR_W, 32, byte-address width of IMEM and DMEM ports
- DATA_W, 32, word width
- RESET_HOLD_CYCLES, 6, core reset assertion length with core clock running (≥1)
- WATCHDOG_CYCLES, 1000, max RUN cycles before timeout (≥2)
- TOHOST_ADDR, 32'h0000_1000, DMEM byte address of end-of-test mailbox
- clk  in  1  system clock (free-running, not gated)
- rstn  in  1  one clock; reset is asynchronous and active-low
- start  in  1  single-cycle pulse; begins a load/run sequence
- load_valid  in  1  image word valid
- load_ready  out  1  controller accepts image word
- load_addr  in  ADDR_W  IMEM byte address of word (word-aligned)
- load_data  in  DATA_W  image word
- load_last  in  1  final word of image
- imem_we  out  1  IMEM write strobe
- imem_addr  out  ADDR_W  IMEM write address
- imem_wdata  out  DATA_W  IMEM write data
- core_clk_en  out  1  enable to core ClockGate
- core_rstn  out  1  core reset, active-low
- dmem_we  in  1  core data store strobe (snooped)
- dmem_addr  in  ADDR_W  core store address
- dmem_wdata  in  DATA_W  core store data
- done  out  1  sequence finished (sticky until next start)
- pass  out  1  valid with done; tohost value was 1
- timeout  out  1  valid with done; watchdog expired
- exit_code  out  DATA_W-1  tohost value >> 1; 0 on pass/timeout

## Operation
- States: IDLE, LOAD, RST_HOLD, RUN, DONE.
- Reset: state IDLE; load_ready, imem_we, core_clk_en, done, pass, timeout = 0; core_rstn = 0; imem_addr, imem_wdata, exit_code = 0.
- IDLE: start → LOAD. All other inputs ignored.
- LOAD: load_ready = 1. Each valid&ready handshake registers addr/data to IMEM outputs with imem_we = 1 for exactly one cycle. A handshake with load_last moves to RST_HOLD. Misaligned load_addr (low 2 bits ≠ 0) is written with low bits forced to 0.
- RST_HOLD: core_clk_en = 1, core_rstn = 0 for exactly RESET_HOLD_CYCLES cycles, then RUN.
- RUN: core_rstn = 1, core_clk_en = 1, watchdog counts from 0 each cycle.
  - Store with dmem_we & dmem_addr == TOHOST_ADDR → DONE. pass = (wdata == 1), exit_code = wdata >> 1 if fail.
  - Watchdog count == WATCHDOG_CYCLES-1 with no tohost store → DONE, timeout = 1, pass = 0.
  - Tohost store and expiry in the same cycle: tohost wins, timeout = 0.
  - Stores to other addresses are ignored.
- DONE: core_clk_en = 0, core_rstn stays 1 (core state frozen for inspection), done = 1. start → LOAD, clears done/pass/timeout/exit_code, drops core_rstn to 0.
- start is ignored in LOAD, RST_HOLD and RUN.
- rstn assertion in any state: immediate return to reset values. Core is held in reset and gated off.

## Timing
- IMEM write appears the cycle after the handshake (1-cycle registered latency). The last word is written in the first RST_HOLD cycle.
- start at cycle T → load_ready = 1 at T+1.
- core_rstn rises exactly RESET_HOLD_CYCLES cycles after core_clk_en rises.
- Tohost detect at cycle T → done/pass registered at T+1, core_clk_en = 0 at T+1.
- Timeout: done = 1 exactly WATCHDOG_CYCLES cycles after the first RUN cycle.
- All outputs registered; no combinational input→output paths except load_ready (state-decoded only).

## Structure
- core_boot_pkg: state enum, TOHOST_PASS_VAL = 1, default TOHOST_ADDR, and the exit-code shift.
- Sub-module: existing UpCounter (WIDTH = $clog2(WATCHDOG_CYCLES)) as the watchdog.
  - en in RUN; clear on RUN entry.
  - Expiry is compared against count_val, not its overflow.
- The same counter instance is reused for the RST_HOLD count, cleared on state entry.

## Test plan
- Load 4 words (0x00000013 ×3, last 0x00100073) at 0,4,8,C → imem_we pulses 4 times, one cycle after each handshake. core_rstn rises 6 cycles after core_clk_en.
- RUN, core stores 1 to 0x1000 → next cycle done = 1, pass = 1, timeout = 0, core_clk_en = 0.
- Store 0x0000000B to 0x1000 → done = 1, pass = 0, exit_code = 5.
- No tohost store → done = 1, timeout = 1 exactly 1000 cycles into RUN. Tohost store on the expiry cycle → pass path wins, timeout = 0.
- Store 1 to 0x1004, then pulse start during RUN → no done, no restart.
- rstn low mid-LOAD and mid-RUN → all outputs at reset values. The next start runs a clean sequence, and a second start from DONE reruns it.
